// File: rtl/xoodyak_hash_stream.sv
// Streaming Xoodyak hash controller: absorbs message bytes into a 384-bit
// state and squeezes the digest, driving an external XOODOO permutation.
module xoodyak_hash_stream #(
    parameter int RATE_BYTES = 16,
    parameter int HASH_BYTES = 32
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         msg_valid,
    output logic         msg_ready,
    input  logic [7:0]   msg,
    input  logic         msg_last,
    input  logic         msg_empty,
    output logic         xoodoo_enable,
    output logic [383:0] state_out,
    input  logic [383:0] state_in,
    input  logic         xoodoo_complete,
    output logic [7:0]   hash,
    output logic         hash_valid,
    input  logic         hash_ready,
    output logic         hash_last,
    output logic         busy
);

    typedef enum logic [2:0] {
        IDLE,
        ABSORB,
        PAD,
        PERM,
        SQUEEZE
    } fsm_e;

    localparam logic [5:0] RATE  = 6'(RATE_BYTES);
    localparam logic [5:0] RLAST = 6'(RATE_BYTES - 1);
    localparam logic [7:0] HLAST = 8'(HASH_BYTES - 1);

    fsm_e         fsm_q, fsm_d;
    logic [383:0] st_q, st_d;
    logic [5:0]   cnt_q, cnt_d;
    logic [5:0]   scnt_q, scnt_d;
    logic [7:0]   dcnt_q, dcnt_d;
    logic         last_q, last_d;
    logic         first_q, first_d;
    logic [8:0]   cidx, sidx;
    logic         take, give;

    assign cidx          = {cnt_q, 3'b000};
    assign sidx          = {scnt_q, 3'b000};
    assign msg_ready     = (fsm_q == IDLE) || (fsm_q == ABSORB);
    assign xoodoo_enable = (fsm_q == PERM);
    assign hash_valid    = (fsm_q == SQUEEZE);
    assign hash_last     = hash_valid && (dcnt_q == HLAST);
    assign hash          = hash_valid ? st_q[sidx +: 8] : 8'h00;
    assign busy          = (fsm_q != IDLE);
    assign state_out     = st_q;
    assign take          = msg_valid && msg_ready;
    assign give          = hash_valid && hash_ready;

    always_comb begin
        fsm_d   = fsm_q;
        st_d    = st_q;
        cnt_d   = cnt_q;
        scnt_d  = scnt_q;
        dcnt_d  = dcnt_q;
        last_d  = last_q;
        first_d = first_q;
        unique case (fsm_q)
            IDLE, ABSORB: begin
                if (fsm_q == IDLE) begin
                    first_d = 1'b1;
                end
                if (take) begin
                    if (!msg_empty) begin
                        st_d[cidx +: 8] = st_q[cidx +: 8] ^ msg;
                        cnt_d = cnt_q + 6'd1;
                    end
                    last_d = msg_last;
                    fsm_d  = (msg_last || cnt_d == RATE) ? PAD : ABSORB;
                end
            end
            PAD: begin
                // Byte 47 carries the hash-mode Cd bit on the first block only.
                st_d[cidx +: 8] = st_q[cidx +: 8] ^ 8'h01;
                if (first_q) begin
                    st_d[383:376] = st_d[383:376] ^ 8'h01;
                end
                cnt_d   = 6'd0;
                first_d = 1'b0;
                fsm_d   = PERM;
            end
            PERM: begin
                if (xoodoo_complete) begin
                    st_d  = state_in;
                    fsm_d = last_q ? SQUEEZE : ABSORB;
                end
            end
            SQUEEZE: begin
                if (give) begin
                    if (hash_last) begin
                        st_d   = '0;
                        scnt_d = 6'd0;
                        dcnt_d = 8'd0;
                        last_d = 1'b0;
                        fsm_d  = IDLE;
                    end else begin
                        dcnt_d = dcnt_q + 8'd1;
                        if (scnt_q == RLAST) begin
                            scnt_d     = 6'd0;
                            st_d[7:0]  = st_q[7:0] ^ 8'h01;
                            fsm_d      = PERM;
                        end else begin
                            scnt_d = scnt_q + 6'd1;
                        end
                    end
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fsm_q   <= IDLE;
            st_q    <= '0;
            cnt_q   <= 6'd0;
            scnt_q  <= 6'd0;
            dcnt_q  <= 8'd0;
            last_q  <= 1'b0;
            first_q <= 1'b1;
        end else begin
            fsm_q   <= fsm_d;
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            scnt_q  <= scnt_d;
            dcnt_q  <= dcnt_d;
            last_q  <= last_d;
            first_q <= first_d;
        end
    end

endmodule

// File: tb/tb_xoodyak_hash_stream.sv
// Bench for xoodyak_hash_stream: a local XOODOO model serves two instances
// and digests are scored against a software Xoodyak hash model.
`timescale 1ns/1ps
module tb_xoodyak_hash_stream;

    localparam int AR = 16;
    localparam int AH = 32;
    localparam int BR = 8;
    localparam int BH = 20;

    typedef struct {
        int len;
        bit sep;
        int stall;
        bit hold;
        bit sel;
        int eperms;
        int ebytes;
    } vec_t;

    logic         clk = 1'b0;
    logic         resetn = 1'b1;
    logic         sel = 1'b0;
    logic         msg_valid = 1'b0;
    logic [7:0]   msg = 8'h00;
    logic         msg_last = 1'b0;
    logic         msg_empty = 1'b0;
    logic         hash_ready = 1'b0;

    logic         mv [2];
    logic         hr [2];
    logic         mr [2];
    logic         en [2];
    logic [383:0] so [2];
    logic [383:0] si [2];
    logic         cmp [2];
    logic [7:0]   hb [2];
    logic         hv [2];
    logic         hl [2];
    logic         bz [2];
    logic         en_q [2];
    int           ecnt [2];
    int           perms [2];
    logic [383:0] snap [2][256];

    logic         mrdy, shv, shl, sbz;
    logic [7:0]   shb;
    int           lat = 1;
    int           frz_bad = 0;
    int           nchk = 0;
    int           nerr = 0;
    logic [8:0]   exp_q [$];

    always #5 clk = ~clk;

    always_comb begin
        mv[0] = msg_valid && !sel;
        mv[1] = msg_valid && sel;
        hr[0] = hash_ready && !sel;
        hr[1] = hash_ready && sel;
        mrdy  = sel ? mr[1] : mr[0];
        shv   = sel ? hv[1] : hv[0];
        shl   = sel ? hl[1] : hl[0];
        sbz   = sel ? bz[1] : bz[0];
        shb   = sel ? hb[1] : hb[0];
    end

    xoodyak_hash_stream #(.RATE_BYTES(AR), .HASH_BYTES(AH)) dut_a (
        .clk(clk), .resetn(resetn),
        .msg_valid(mv[0]), .msg_ready(mr[0]), .msg(msg),
        .msg_last(msg_last), .msg_empty(msg_empty),
        .xoodoo_enable(en[0]), .state_out(so[0]), .state_in(si[0]),
        .xoodoo_complete(cmp[0]),
        .hash(hb[0]), .hash_valid(hv[0]), .hash_ready(hr[0]),
        .hash_last(hl[0]), .busy(bz[0])
    );

    xoodyak_hash_stream #(.RATE_BYTES(BR), .HASH_BYTES(BH)) dut_b (
        .clk(clk), .resetn(resetn),
        .msg_valid(mv[1]), .msg_ready(mr[1]), .msg(msg),
        .msg_last(msg_last), .msg_empty(msg_empty),
        .xoodoo_enable(en[1]), .state_out(so[1]), .state_in(si[1]),
        .xoodoo_complete(cmp[1]),
        .hash(hb[1]), .hash_valid(hv[1]), .hash_ready(hr[1]),
        .hash_last(hl[1]), .busy(bz[1])
    );

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [383:0] xoodoo(input logic [383:0] s);
        logic [31:0]  a [12];
        logic [31:0]  p [4];
        logic [31:0]  t [4];
        logic [11:0]  rc [12];
        logic [31:0]  e, b0, b1, b2;
        logic [383:0] r;
        rc = '{12'h058, 12'h038, 12'h3C0, 12'h0D0, 12'h120, 12'h014,
               12'h060, 12'h02C, 12'h380, 12'h0F0, 12'h1A0, 12'h012};
        for (int i = 0; i < 12; i++) a[i] = s[32*i +: 32];
        for (int rd = 0; rd < 12; rd++) begin
            for (int x = 0; x < 4; x++) p[x] = a[x] ^ a[4+x] ^ a[8+x];
            for (int x = 0; x < 4; x++) begin
                e = rotl(p[(x+3)%4], 5) ^ rotl(p[(x+3)%4], 14);
                a[x] ^= e;
                a[4+x] ^= e;
                a[8+x] ^= e;
            end
            for (int x = 0; x < 4; x++) t[x] = a[4+x];
            for (int x = 0; x < 4; x++) begin
                a[4+x] = t[(x+3)%4];
                a[8+x] = rotl(a[8+x], 11);
            end
            a[0] ^= {20'h0, rc[rd]};
            for (int x = 0; x < 4; x++) begin
                b0 = ~a[4+x] & a[8+x];
                b1 = ~a[8+x] & a[x];
                b2 = ~a[x] & a[4+x];
                a[x] ^= b0;
                a[4+x] ^= b1;
                a[8+x] ^= b2;
            end
            for (int x = 0; x < 4; x++) t[x] = a[8+x];
            for (int x = 0; x < 4; x++) begin
                a[4+x] = rotl(a[4+x], 1);
                a[8+x] = rotl(t[(x+2)%4], 8);
            end
        end
        for (int i = 0; i < 12; i++) r[32*i +: 32] = a[i];
        return r;
    endfunction

    // XOODOO stand-in: completes lat cycles after enable, checks the input
    // state stayed frozen, and snapshots the state seen on each request.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < 2; k++) begin
                cmp[k]  <= 1'b0;
                ecnt[k] <= 0;
                en_q[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                en_q[k] <= en[k];
                cmp[k]  <= 1'b0;
                if (en[k] && !en_q[k]) snap[k][perms[k] % 256] <= so[k];
                if (en[k] && !cmp[k]) begin
                    if (ecnt[k] >= lat) begin
                        cmp[k]   <= 1'b1;
                        si[k]    <= xoodoo(so[k]);
                        ecnt[k]  <= 0;
                        perms[k] <= perms[k] + 1;
                        if (en_q[k] && so[k] != snap[k][perms[k] % 256])
                            frz_bad <= frz_bad + 1;
                    end else begin
                        ecnt[k] <= ecnt[k] + 1;
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [383:0] act,
                       input logic [383:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_push(input int len, input bit sep,
                              input int rate, input int hlen);
        logic [383:0] s;
        int nblk, st, bl, outn, n;
        s = '0;
        if (len == 0) nblk = 1;
        else if (len % rate == 0) nblk = len / rate + (sep ? 1 : 0);
        else nblk = (len + rate - 1) / rate;
        for (int b = 0; b < nblk; b++) begin
            if (b > 0) s = xoodoo(s);
            st = b * rate;
            bl = (len - st < rate) ? len - st : rate;
            for (int i = 0; i < bl; i++) s[8*i +: 8] ^= 8'(st + i);
            s[8*bl +: 8] ^= 8'h01;
            if (b == 0) s[383:376] ^= 8'h01;
        end
        s = xoodoo(s);
        outn = 0;
        while (outn < hlen) begin
            n = (hlen - outn < rate) ? hlen - outn : rate;
            for (int i = 0; i < n; i++) begin
                exp_q.push_back({s[8*i +: 8], outn == hlen - 1});
                outn++;
            end
            if (outn < hlen) begin
                s[7:0] ^= 8'h01;
                s = xoodoo(s);
            end
        end
    endtask

    task automatic send(input int len, input bit sep, input bit hold);
        int nb, to;
        nb = (len == 0) ? 1 : len + (sep ? 1 : 0);
        for (int i = 0; i < nb; i++) begin
            @(negedge clk);
            msg_valid = 1'b1;
            msg       = (i < len) ? 8'(i) : 8'h00;
            msg_empty = (i >= len);
            msg_last  = (i == nb - 1);
            to = 0;
            while (!mrdy && to < 200) begin
                @(negedge clk);
                to++;
            end
            if (to >= 200) chk("beat_accept_timeout", 1'b1, 1'b0);
        end
        @(negedge clk);
        msg_valid = hold;
        msg       = hold ? 8'hA5 : 8'h00;
        msg_last  = 1'b0;
        msg_empty = 1'b0;
    endtask

    task automatic rx(input int nbytes, input int stall_at, input bit hold);
        int got, to;
        logic [9:0] sv;
        logic [8:0] e;
        got = 0;
        to  = 0;
        hash_ready = 1'b1;
        while (got < nbytes && to < 3000) begin
            @(negedge clk);
            if (hold) chk("msg_ready_while_busy", mrdy, 1'b0);
            if (shv) begin
                if (got == 0) chk("busy_high", sbz, 1'b1);
                if (got == stall_at) begin
                    hash_ready = 1'b0;
                    sv = {shb, shv, shl};
                    repeat (5) begin
                        @(negedge clk);
                        chk("stall_stable", {shb, shv, shl}, sv);
                    end
                    hash_ready = 1'b1;
                end
                if (hold && shl) msg_valid = 1'b0;
                e = exp_q.pop_front();
                chk("digest_byte", {shb, shl}, e);
                got++;
            end else begin
                to++;
            end
        end
        chk("digest_count", got, nbytes);
        @(negedge clk);
        msg_valid = 1'b0;
        chk("busy_fall", sbz, 1'b0);
        chk("hash_valid_after", shv, 1'b0);
        exp_q.delete();
    endtask

    task automatic run_msg(input int len, input bit sep, input int stall_at,
                           input bit hold, input bit s, input int eperms,
                           input int ebytes);
        int p0;
        sel = s;
        lat = $urandom_range(0, 3);
        p0  = s ? perms[1] : perms[0];
        model_push(len, sep, s ? BR : AR, s ? BH : AH);
        send(len, sep, hold);
        rx(ebytes, stall_at, hold);
        chk("perm_count", (s ? perms[1] : perms[0]) - p0, eperms);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_msg_ready", mr[0], 1'b1);
        chk("rst_enable", en[0], 1'b0);
        chk("rst_state_out", so[0], '0);
        chk("rst_hash", hb[0], 8'h00);
        chk("rst_hash_valid", hv[0], 1'b0);
        chk("rst_hash_last", hl[0], 1'b0);
        chk("rst_busy", bz[0], 1'b0);
        chk("rst_busy_b", bz[1], 1'b0);
    endtask

    initial begin
        vec_t         vecs [8];
        logic [383:0] e1, e2;
        int           p0, to;

        vecs[0] = '{1,  1'b0, -1, 1'b0, 1'b0, 2, AH};
        vecs[1] = '{16, 1'b0, -1, 1'b1, 1'b0, 2, AH};
        vecs[2] = '{16, 1'b1, -1, 1'b0, 1'b0, 3, AH};
        vecs[3] = '{32, 1'b0,  3, 1'b0, 1'b0, 3, AH};
        vecs[4] = '{19, 1'b1, -1, 1'b0, 1'b0, 3, AH};
        vecs[5] = '{19, 1'b0, -1, 1'b0, 1'b1, 5, BH};
        vecs[6] = '{16, 1'b0, -1, 1'b0, 1'b1, 4, BH};
        vecs[7] = '{46, 1'b0, -1, 1'b0, 1'b0, 4, AH};

        #2 resetn = 1'b0;
        #1;
        chk_reset_outputs();
        @(negedge clk);
        resetn = 1'b1;

        p0 = perms[0];
        run_msg(0, 1'b1, -1, 1'b0, 1'b0, 2, AH);
        e1 = '0;
        e1[7:0] = 8'h01;
        e1[383:376] = 8'h01;
        chk("empty_first_perm_in", snap[0][p0 % 256], e1);

        p0 = perms[0];
        run_msg(19, 1'b0, -1, 1'b0, 1'b0, 3, AH);
        e1 = '0;
        for (int i = 0; i < 16; i++) e1[8*i +: 8] = 8'(i);
        e1[135:128] = 8'h01;
        e1[383:376] = 8'h01;
        chk("m19_first_perm_in", snap[0][p0 % 256], e1);
        e2 = xoodoo(e1);
        e2[7:0]   ^= 8'h10;
        e2[15:8]  ^= 8'h11;
        e2[23:16] ^= 8'h12;
        e2[31:24] ^= 8'h01;
        chk("m19_second_perm_in", snap[0][(p0 + 1) % 256], e2);

        for (int v = 0; v < 8; v++) begin
            run_msg(vecs[v].len, vecs[v].sep, vecs[v].stall, vecs[v].hold,
                    vecs[v].sel, vecs[v].eperms, vecs[v].ebytes);
        end

        // Abort a message in the middle of its second permutation.
        sel = 1'b0;
        lat = 30;
        p0  = perms[0];
        send(19, 1'b0, 1'b0);
        to = 0;
        while (!(perms[0] == p0 + 1 && en[0]) && to < 500) begin
            @(negedge clk);
            to++;
        end
        chk("reach_second_perm", to < 500, 1'b1);
        repeat (3) @(negedge clk);
        chk("mid_perm_enable", en[0], 1'b1);
        resetn = 1'b0;
        #1;
        chk_reset_outputs();
        @(negedge clk);
        resetn = 1'b1;
        run_msg(19, 1'b0, -1, 1'b0, 1'b0, 3, AH);

        chk("perm_input_frozen", frz_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
